// File: rtl/wb_sram_slave.sv
// wb_sram_slave
//   Word-addressed Wishbone-style single-port RAM slave. Each accepted request
//   waits WAIT_STATES cycles and then performs one whole-word access under a
//   byte mask. Completion is signalled by a one-cycle ack pulse.
//
// Parameters
//   ADDR_WIDTH  : word-address bits; the RAM holds 2^ADDR_WIDTH x 32 bits
//   WAIT_STATES : extra cycles between accept and access (0..15)
//
// Ports
//   i_clk, i_reset_n : clock (rising edge), async active-low reset
//   i_wb_stb         : request strobe, only looked at while idle
//   i_wb_we          : 1 = write, 0 = read
//   i_wb_addr        : word address
//   i_wb_data        : write data
//   i_wb_sel         : byte-lane write mask (bit n -> bits [8n+7:8n])
//   o_wb_ack         : one-cycle completion pulse
//   o_wb_stall       : high while a request is in flight
//   o_wb_data        : read word, valid with o_wb_ack
//
// Optional feature
//   WB_SRAM_BOUNDS_CHECK_EN : when defined, addresses with any bit set above
//   ADDR_WIDTH still complete normally, but writes are dropped and reads
//   return all ones. When undefined, upper address bits are ignored and
//   addresses alias modulo the depth.

module wb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [LANES-1:0]      sel;
        logic [31:0]           data;
        logic [ADDR_WIDTH-1:0] idx;
    } req_t;

    logic [0:0]  state;
    logic [3:0]  cnt;
    req_t        req;
    logic        accept;
    logic        access;
    logic        wr_en;
    logic [31:0] rd_word;
    logic [31:0] mem [DEPTH];

`ifdef WB_SRAM_BOUNDS_CHECK_EN
    logic oob;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            oob <= 1'b0;
        end else if (accept) begin
            oob <= |i_wb_addr[31:ADDR_WIDTH];
        end
    end

    assign wr_en   = access && req.we && !oob;
    assign rd_word = oob ? 32'hFFFF_FFFF : mem[req.idx];
`else
    // Upper address bits deliberately dropped: addresses alias.
    logic addr_unused;
    assign addr_unused = ^i_wb_addr[31:ADDR_WIDTH];

    assign wr_en   = access && req.we;
    assign rd_word = mem[req.idx];
`endif

    assign accept = (state == IDLE) && i_wb_stb && !o_wb_stall;
    assign access = (state == BUSY) && (cnt == 4'd0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req        <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_stall <= 1'b0;
            o_wb_data  <= 32'hFFFF_FFFF;
        end else begin
            // Ack is a single-cycle pulse regardless of what follows.
            o_wb_ack <= 1'b0;
            if (accept) begin
                state      <= BUSY;
                cnt        <= 4'(WAIT_STATES);
                req        <= '{we: i_wb_we, sel: i_wb_sel, data: i_wb_data,
                                idx: i_wb_addr[ADDR_WIDTH-1:0]};
                o_wb_stall <= 1'b1;
            end else if (state == BUSY) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state      <= IDLE;
                    o_wb_ack   <= 1'b1;
                    o_wb_stall <= 1'b0;
                    if (!req.we) begin
                        o_wb_data <= rd_word;
                    end
                end
            end
        end
    end

    // RAM array is never reset; a write only lands on its access edge, so a
    // reset before that edge discards it.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (req.sel[b]) begin
                    mem[req.idx][8*b +: 8] <= req.data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave
//   Directed bench for wb_sram_slave (ADDR_WIDTH = 4, WAIT_STATES = 1).
//   A transaction-level model predicts ack, stall and read data from the
//   accept edge plus fixed latency; a compare process checks every cycle,
//   and the directed sequences pin latencies and read words to literals.

module tb_wb_sram_slave;

    localparam int AW = 4;
    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        ack;
    logic        stall;
    logic [31:0] rdata;

    int cmp_cnt = 0;
    int err_cnt = 0;

    wb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .o_wb_ack   (ack),
        .o_wb_stall (stall),
        .o_wb_data  (rdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    logic [31:0] mmem [1 << AW];
    logic        m_busy  = 1'b0;
    longint      m_done  = 0;
    longint      cyc     = 0;
    logic        m_we;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_sel;
    logic        e_ack   = 1'b0;
    logic        e_stall = 1'b0;
    logic [31:0] e_data  = 32'hFFFF_FFFF;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy  = 1'b0;
            e_ack   = 1'b0;
            e_stall = 1'b0;
            e_data  = 32'hFFFF_FFFF;
        end else begin
            cyc++;
            e_ack = 1'b0;
            if (m_busy) begin
                if (cyc == m_done) begin
                    logic oob;
                    int   i;
                    logic [31:0] mask;
`ifdef WB_SRAM_BOUNDS_CHECK_EN
                    oob = (m_addr >= (32'd1 << AW));
`else
                    oob = 1'b0;
`endif
                    i = int'(m_addr % (32'd1 << AW));
                    mask = {{8{m_sel[3]}}, {8{m_sel[2]}}, {8{m_sel[1]}}, {8{m_sel[0]}}};
                    if (m_we) begin
                        if (!oob) mmem[i] = (mmem[i] & ~mask) | (m_data & mask);
                    end else begin
                        e_data = oob ? 32'hFFFF_FFFF : mmem[i];
                    end
                    e_ack   = 1'b1;
                    e_stall = 1'b0;
                    m_busy  = 1'b0;
                end
            end else if (stb) begin
                m_busy  = 1'b1;
                m_done  = cyc + 1 + WS;
                m_we    = we;
                m_addr  = addr;
                m_data  = wdata;
                m_sel   = sel;
                e_stall = 1'b1;
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("cyc_ack",   {31'd0, ack},   {31'd0, e_ack});
        chk("cyc_stall", {31'd0, stall}, {31'd0, e_stall});
        chk("cyc_data",  rdata,          e_data);
        if (ack && stall) chk("ack_stall_overlap", {31'd0, stall}, 32'd0);
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int lat);
        logic got;
        @(negedge clk);
        stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(posedge clk);
        #1 stb = 1'b0;
        lat = 0;
        rd  = 'x;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack) begin
                got = 1'b1;
                rd  = rdata;
            end
        end
        if (!got) chk("ack_timeout", {31'd0, ack}, 32'd1);
    endtask

    logic [31:0] rd;
    int          lat;
    int          acks;

    initial begin
        rst_n = 1'b0;
        stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack",   {31'd0, ack},   32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_data",  rdata,          32'hFFFF_FFFF);
        rst_n = 1'b1;

        // Full-word round trip
        do_req(1'b1, 32'd5, 32'hDEAD_BEEF, 4'b1111, rd, lat);
        chk("wr_latency", lat, 32'd2);
        do_req(1'b0, 32'd5, 32'h0, 4'b0000, rd, lat);
        chk("rd_latency", lat, 32'd2);
        chk("rd_full", rd, 32'hDEAD_BEEF);

        // Byte lane and empty-mask writes
        do_req(1'b1, 32'd5, 32'hFFAA_FFFF, 4'b0100, rd, lat);
        do_req(1'b0, 32'd5, 32'h0, 4'b1111, rd, lat);
        chk("rd_lane2", rd, 32'hDEAA_BEEF);
        do_req(1'b1, 32'd5, 32'h0000_0000, 4'b0000, rd, lat);
        chk("sel0_latency", lat, 32'd2);
        do_req(1'b0, 32'd5, 32'h0, 4'b0000, rd, lat);
        chk("rd_sel0", rd, 32'hDEAA_BEEF);

        // Back-to-back: next accept on the edge where ack falls
        do_req(1'b0, 32'd5, 32'h0, 4'b0000, rd, lat);
        @(negedge clk);
        chk("b2b_idle_stall", {31'd0, stall}, 32'd0);

        // Strobes while stalled are dropped
        do_req(1'b1, 32'd8, 32'h0000_0000, 4'b1111, rd, lat);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; addr = 32'd7; wdata = 32'hA5A5_A5A5; sel = 4'b1111;
        @(negedge clk);  // accepted at the edge just passed
        addr = 32'd8; wdata = 32'h5A5A_5A5A;
        @(negedge clk);  // held through one stalled edge
        stb = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 if (ack) acks++;
        end
        chk("drop_ack_count", acks, 32'd1);
        do_req(1'b0, 32'd7, 32'h0, 4'b0000, rd, lat);
        chk("drop_first", rd, 32'hA5A5_A5A5);
        do_req(1'b0, 32'd8, 32'h0, 4'b0000, rd, lat);
        chk("drop_second", rd, 32'h0000_0000);

        // Bounds / aliasing
        do_req(1'b1, 32'd0,  32'h1234_5678, 4'b1111, rd, lat);
        do_req(1'b1, 32'd16, 32'hCAFE_F00D, 4'b1111, rd, lat);
        chk("oob_wr_latency", lat, 32'd2);
        do_req(1'b0, 32'd16, 32'h0, 4'b0000, rd, lat);
`ifdef WB_SRAM_BOUNDS_CHECK_EN
        chk("oob_rd16", rd, 32'hFFFF_FFFF);
`else
        chk("alias_rd16", rd, 32'hCAFE_F00D);
`endif
        do_req(1'b0, 32'd0, 32'h0, 4'b0000, rd, lat);
`ifdef WB_SRAM_BOUNDS_CHECK_EN
        chk("oob_rd0", rd, 32'h1234_5678);
`else
        chk("alias_rd0", rd, 32'hCAFE_F00D);
`endif

        // Reset abort of a pending write
        do_req(1'b1, 32'd2, 32'h1111_1111, 4'b1111, rd, lat);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; addr = 32'd2; wdata = 32'h0; sel = 4'b1111;
        @(posedge clk);   // accept edge
        #1 stb = 1'b0;
        chk("abort_stall_hi", {31'd0, stall}, 32'd1);
        @(posedge clk);   // counting edge, access would be next
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ack",   {31'd0, ack},   32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        chk("async_rst_data",  rdata,          32'hFFFF_FFFF);
        acks = 0;
        @(posedge clk);
        #1 if (ack) acks++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 if (ack) acks++;
        end
        chk("abort_no_ack", acks, 32'd0);
        do_req(1'b0, 32'd2, 32'h0, 4'b0000, rd, lat);
        chk("abort_rd2", rd, 32'h1111_1111);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", {31'd0, ack}, 32'hFFFF_FFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
